uhci_mem_arbiter: RTL and testbench

- Shares the 1 KB dual-port TD/frame buffer memory between the UHCI schedule engine and the AXI slave.
- The UHCI engine drives the 128-bit port A; the AXI slave drives the 32-bit port B.
- The memory gives port B absolute priority, so a colliding port-A access would be silently dropped. This block prevents that.
- It keeps En_A and En_B mutually exclusive, applies bounded-fairness arbitration, and returns read data with a valid strobe aligned to the memory's one-cycle read latency.

---
 rtl/uhci_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_uhci_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uhci_mem_arbiter.sv
// uhci_mem_arbiter
// Arbitrates the shared TD/frame buffer memory between the UHCI schedule
// engine (128-bit port A) and the AXI slave (32-bit port B). The memory gives
// port B absolute priority, so this block makes sure that only one port is
// enabled in any cycle. UHCI is normally preferred, and AXI is guaranteed a
// slot after MAX_BURST back-to-back UHCI grants. A UHCI read-modify-write lock
// can hold the memory across several accesses.
//
// Handshake: a requester raises *_req with its fields stable and holds them
// until it sees *_gnt high in the same cycle. The access is issued to the
// memory in that cycle. A read's data comes back with *_rvalid one cycle
// later. There is no backpressure on the read return.
module uhci_mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 32,
  parameter int MAX_BURST  = 4,
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // UHCI schedule engine side
  input  logic                  u_req,
  input  logic                  u_lock,
  input  logic [NUM_COL-1:0]    u_we,
  input  logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [DATA_WIDTH-1:0] u_wdata,
  output logic                  u_gnt,
  output logic                  u_rvalid,
  output logic [DATA_WIDTH-1:0] u_rdata,
  // AXI slave side
  input  logic                  x_req,
  input  logic [NUM_COL-1:0]    x_we,
  input  logic [NUM_COL-1:0]    x_re,
  input  logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [COL_WIDTH-1:0]  x_wdata,
  output logic                  x_gnt,
  output logic                  x_rvalid,
  output logic [COL_WIDTH-1:0]  x_rdata,
  output logic                  x_err,
  // memory port A
  output logic                  En_A,
  output logic [NUM_COL-1:0]    w_A,
  output logic [ADDR_WIDTH-1:0] addrA,
  output logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] doutA,
  // memory port B
  output logic                  En_B,
  output logic [NUM_COL-1:0]    w_B,
  output logic [NUM_COL-1:0]    r_B,
  output logic [ADDR_WIDTH-1:0] addrB,
  output logic [COL_WIDTH-1:0]  dinB,
  input  logic [COL_WIDTH-1:0]  doutB,
  // observability of the arbiter state
  output logic                  dbg_state,
  output logic [3:0]            dbg_burst_cnt,
  output logic [1:0]            dbg_last_owner
);

  typedef enum logic {
    U_PRI   = 1'b0,
    X_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_U    = 2'd1,
    OWN_X    = 2'd2
  } owner_e;

  localparam logic [3:0]         BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [NUM_COL-1:0] COL_ONE    = NUM_COL'(1);

  // True when the select vector is zero or has exactly one bit set.
  function automatic logic onehot0(input logic [NUM_COL-1:0] v);
    return (v & (v - COL_ONE)) == '0;
  endfunction

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] burst_q, burst_d;
  logic       lock_active;

  logic                  u_rvalid_q;
  logic                  x_rvalid_q;
  logic                  x_err_q;
  logic [DATA_WIDTH-1:0] u_rdata_q;
  logic [COL_WIDTH-1:0]  x_rdata_q;

  // The lock only applies when UHCI already holds the memory. It cannot be
  // used to take the memory away from an AXI access.
  assign lock_active = u_lock & u_req & (owner_q == OWN_U);

  // Grant selection, burst accounting and next-state logic.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    owner_d = owner_q;
    u_gnt   = 1'b0;
    x_gnt   = 1'b0;

    case (state_q)
      U_PRI: begin
        if (lock_active || u_req) begin
          u_gnt = 1'b1;
        end else if (x_req) begin
          x_gnt = 1'b1;
        end
      end
      X_FORCE: begin
        // A held lock defers the forced AXI slot. It does not cancel it.
        if (lock_active) begin
          u_gnt = 1'b1;
        end else if (x_req) begin
          x_gnt   = 1'b1;
          state_d = U_PRI;
        end else begin
          // The AXI request was withdrawn. Fall back without granting.
          state_d = U_PRI;
        end
      end
      default: state_d = U_PRI;
    endcase

    // Count UHCI grants only while AXI is actually waiting.
    if (x_gnt || !x_req) begin
      burst_d = '0;
    end else if (u_gnt && !lock_active) begin
      if (burst_q == BURST_LAST) begin
        state_d = X_FORCE;
      end else begin
        burst_d = burst_q + 4'd1;
      end
    end

    if (u_gnt) begin
      owner_d = OWN_U;
    end else if (x_gnt) begin
      owner_d = OWN_X;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= U_PRI;
      burst_q <= '0;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      owner_q <= owner_d;
    end
  end

  // Memory control. The idle port sees all-zero controls.
  assign En_A  = u_gnt;
  assign w_A   = u_gnt ? u_we    : '0;
  assign addrA = u_gnt ? u_addr  : '0;
  assign dinA  = u_gnt ? u_wdata : '0;

  assign En_B  = x_gnt;
  assign w_B   = x_gnt ? x_we    : '0;
  assign r_B   = x_gnt ? x_re    : '0;
  assign addrB = x_gnt ? x_addr  : '0;
  assign dinB  = x_gnt ? x_wdata : '0;

  // Read-valid and encoding-error strobes track the one-cycle memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_rvalid_q <= 1'b0;
      x_rvalid_q <= 1'b0;
      x_err_q    <= 1'b0;
    end else begin
      u_rvalid_q <= u_gnt && (u_we == '0);
      x_rvalid_q <= x_gnt && (x_re != '0);
      x_err_q    <= x_gnt && (!onehot0(x_we) || !onehot0(x_re));
    end
  end

  // Hold registers keep the last returned read data between rvalid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_rdata_q <= '0;
      x_rdata_q <= '0;
    end else begin
      if (u_rvalid_q) begin
        u_rdata_q <= doutA;
      end
      if (x_rvalid_q) begin
        x_rdata_q <= doutB;
      end
    end
  end

  // Memory output is forwarded during the rvalid cycle, so the data lines up
  // with the strobe.
  assign u_rdata  = u_rvalid_q ? doutA : u_rdata_q;
  assign x_rdata  = x_rvalid_q ? doutB : x_rdata_q;
  assign u_rvalid = u_rvalid_q;
  assign x_rvalid = x_rvalid_q;
  assign x_err    = x_err_q;

  assign dbg_state      = state_q;
  assign dbg_burst_cnt  = burst_q;
  assign dbg_last_owner = owner_q;

endmodule

// File: tb/tb_uhci_mem_arbiter.sv
// tb_uhci_mem_arbiter
// Bench for uhci_mem_arbiter. It includes a behavioural dual-port memory with a
// one-cycle read latency. It applies a vector table of grant expectations plus
// hand-written multi-cycle sequences. A monitor keeps a shadow copy of the
// memory and queues the expected read data for both ports.
module tb_uhci_mem_arbiter;

  localparam int AW = 6;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int DW = NC * CW;

  logic          clk;
  logic          rst_n;
  logic          u_req, u_lock;
  logic [NC-1:0] u_we;
  logic [AW-1:0] u_addr;
  logic [DW-1:0] u_wdata;
  logic          u_gnt, u_rvalid;
  logic [DW-1:0] u_rdata;
  logic          x_req;
  logic [NC-1:0] x_we, x_re;
  logic [AW-1:0] x_addr;
  logic [CW-1:0] x_wdata;
  logic          x_gnt, x_rvalid, x_err;
  logic [CW-1:0] x_rdata;
  logic          En_A, En_B;
  logic [NC-1:0] w_A, w_B, r_B;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, doutA;
  logic [CW-1:0] dinB, doutB;
  logic          dbg_state;
  logic [3:0]    dbg_burst_cnt;
  logic [1:0]    dbg_last_owner;

  uhci_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .u_req(u_req), .u_lock(u_lock), .u_we(u_we), .u_addr(u_addr),
    .u_wdata(u_wdata), .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
    .x_req(x_req), .x_we(x_we), .x_re(x_re), .x_addr(x_addr),
    .x_wdata(x_wdata), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .x_err(x_err),
    .En_A(En_A), .w_A(w_A), .addrA(addrA), .dinA(dinA), .doutA(doutA),
    .En_B(En_B), .w_B(w_B), .r_B(r_B), .addrB(addrB), .dinB(dinB),
    .doutB(doutB),
    .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt),
    .dbg_last_owner(dbg_last_owner)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- counters / compare ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    if (i == 5) return 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF;
    return {32'(32'hC000_0000 + i * 16 + 3), 32'(32'hC000_0000 + i * 16 + 2),
            32'(32'hC000_0000 + i * 16 + 1), 32'(32'hC000_0000 + i * 16)};
  endfunction

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [64];
  logic          mem_init = 1'b0;

  // Dual-port memory with one-cycle read latency. Illegal B selects are ignored
  // and read back as zero.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else begin
      if (En_A) begin
        doutA <= mem[addrA];
        for (int c = 0; c < NC; c++)
          if (w_A[c]) mem[addrA][c*CW +: CW] <= dinA[c*CW +: CW];
      end
      if (En_B) begin
        doutB <= '0;
        for (int c = 0; c < NC; c++) begin
          if ($onehot(r_B) && r_B[c]) doutB <= mem[addrB][c*CW +: CW];
          if ($onehot(w_B) && w_B[c]) mem[addrB][c*CW +: CW] <= dinB;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] shadow [64];
  logic          shadow_init = 1'b0;
  logic [DW-1:0] u_exp_q [$];
  logic [CW-1:0] exp_q [$];
  logic          exp_u_rv = 1'b0;
  logic          exp_x_rv = 1'b0;
  logic          exp_err  = 1'b0;

  // Checks returns that are due this cycle, then records this cycle's grants.
  always @(negedge clk) begin
    if (!shadow_init) begin
      for (int i = 0; i < 64; i++) shadow[i] = pat(i);
      shadow_init = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_ctrl", {u_gnt, x_gnt, u_rvalid, x_rvalid, x_err, En_A, En_B, w_A, w_B, r_B}, '0);
      chk("rst_u_rdata", u_rdata, '0);
      chk("rst_x_rdata", x_rdata, '0);
      exp_u_rv = 1'b0;
      exp_x_rv = 1'b0;
      exp_err  = 1'b0;
      u_exp_q.delete();
      exp_q.delete();
    end else begin
      chk("u_rvalid", u_rvalid, exp_u_rv);
      chk("x_rvalid", x_rvalid, exp_x_rv);
      chk("x_err", x_err, exp_err);
      if (u_rvalid) begin
        if (u_exp_q.size() > 0) chk("u_rdata", u_rdata, u_exp_q.pop_front());
        else begin n_checks++; $display("FAIL u_rdata: got rvalid, required no return pending"); end
      end
      if (x_rvalid) begin
        if (exp_q.size() > 0) chk("x_rdata", x_rdata, exp_q.pop_front());
        else begin n_checks++; $display("FAIL x_rdata: got rvalid, required no return pending"); end
      end
      chk("en_mutex", En_A & En_B, '0);
      chk("port_a", {En_A, w_A, addrA, dinA},
          u_gnt ? {1'b1, u_we, u_addr, u_wdata} : '0);
      chk("port_b", {En_B, w_B, r_B, addrB, dinB},
          x_gnt ? {1'b1, x_we, x_re, x_addr, x_wdata} : '0);

      exp_u_rv = u_gnt && (u_we == '0);
      exp_x_rv = x_gnt && (x_re != '0);
      exp_err  = x_gnt && (!$onehot0(x_we) || !$onehot0(x_re));
      if (u_gnt) begin
        if (u_we == '0) u_exp_q.push_back(shadow[u_addr]);
        for (int c = 0; c < NC; c++)
          if (u_we[c]) shadow[u_addr][c*CW +: CW] = u_wdata[c*CW +: CW];
      end
      if (x_gnt) begin
        if (x_re != '0) begin
          logic [CW-1:0] d;
          d = '0;
          for (int c = 0; c < NC; c++)
            if ($onehot(x_re) && x_re[c]) d = shadow[x_addr][c*CW +: CW];
          exp_q.push_back(d);
        end
        for (int c = 0; c < NC; c++)
          if ($onehot(x_we) && x_we[c]) shadow[x_addr][c*CW +: CW] = x_wdata;
      end
    end
  end

  // ---------------- vectors / driver ----------------
  typedef struct {
    logic          u_req, u_lock;
    logic [NC-1:0] u_we;
    logic [AW-1:0] u_addr;
    logic [DW-1:0] u_wdata;
    logic          x_req;
    logic [NC-1:0] x_we, x_re;
    logic [AW-1:0] x_addr;
    logic [CW-1:0] x_wdata;
    logic          exp_u_gnt, exp_x_gnt;
  } vec_t;

  function automatic vec_t mk(logic ur, logic ul, logic [NC-1:0] uwe,
                              logic [AW-1:0] ua, logic xr, logic [NC-1:0] xwe,
                              logic [NC-1:0] xre, logic [AW-1:0] xa,
                              logic [CW-1:0] xwd, logic eu, logic ex);
    vec_t v;
    v.u_req = ur; v.u_lock = ul; v.u_we = uwe; v.u_addr = ua;
    v.u_wdata = {$urandom, $urandom, $urandom, $urandom};
    v.x_req = xr; v.x_we = xwe; v.x_re = xre; v.x_addr = xa; v.x_wdata = xwd;
    v.exp_u_gnt = eu; v.exp_x_gnt = ex;
    return v;
  endfunction

  task automatic drive_idle();
    u_req = 0; u_lock = 0; u_we = '0; u_addr = '0; u_wdata = '0;
    x_req = 0; x_we = '0; x_re = '0; x_addr = '0; x_wdata = '0;
  endtask

  task automatic step(input vec_t v, input string name);
    @(posedge clk); #1;
    u_req = v.u_req; u_lock = v.u_lock; u_we = v.u_we; u_addr = v.u_addr;
    u_wdata = v.u_wdata; x_req = v.x_req; x_we = v.x_we; x_re = v.x_re;
    x_addr = v.x_addr; x_wdata = v.x_wdata;
    @(negedge clk);
    chk({name, "_u_gnt"}, u_gnt, v.exp_u_gnt);
    chk({name, "_x_gnt"}, x_gnt, v.exp_x_gnt);
  endtask

  vec_t tbl [17];
  vec_t v;

  initial begin
    rst_n = 1'b0;
    drive_idle();

    //             ur ul uwe     ua  xr xwe     xre     xa  xwdata        eu ex
    tbl[0]  = mk(1, 0, 4'b0000, 5,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[1]  = mk(0, 0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0, 32'h0,        0, 0);
    tbl[2]  = mk(0, 0, 4'b0000, 0,  1, 4'b0010, 4'b0000, 3, 32'h12345678, 0, 1);
    tbl[3]  = mk(0, 0, 4'b0000, 0,  1, 4'b0000, 4'b0010, 3, 32'h0,        0, 1);
    tbl[4]  = mk(0, 0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0, 32'h0,        0, 0);
    tbl[5]  = mk(1, 0, 4'b1111, 9,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[6]  = mk(1, 0, 4'b0000, 9,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[7]  = mk(0, 0, 4'b0000, 0,  1, 4'b0001, 4'b0001, 7, 32'hA5A5_5A5A, 0, 1);
    tbl[8]  = mk(0, 0, 4'b0000, 0,  1, 4'b0000, 4'b0001, 7, 32'h0,        0, 1);
    tbl[9]  = mk(0, 0, 4'b0000, 0,  1, 4'b0000, 4'b0011, 2, 32'h0,        0, 1);
    tbl[10] = mk(1, 0, 4'b0000, 3,  1, 4'b0000, 4'b0100, 3, 32'h0,        1, 0);
    tbl[11] = mk(0, 0, 4'b0000, 0,  1, 4'b0000, 4'b0100, 3, 32'h0,        0, 1);
    tbl[12] = mk(1, 0, 4'b0101, 3,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[13] = mk(1, 0, 4'b0000, 3,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[14] = mk(0, 0, 4'b0000, 0,  1, 4'b1100, 4'b0000, 4, 32'hFFFF_0000, 0, 1);
    tbl[15] = mk(1, 0, 4'b0000, 4,  0, 4'b0000, 4'b0000, 0, 32'h0,        1, 0);
    tbl[16] = mk(0, 0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0, 32'h0,        0, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {dbg_state, dbg_burst_cnt, dbg_last_owner}, '0);

    for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Both requesters saturated: four UHCI grants, then one forced AXI grant.
    for (int i = 0; i < 10; i++) begin
      v = mk(1, 0, 4'b0000, 6'($urandom_range(0, 63)), 1, 4'b0000, 4'b0001, 12,
             32'h0, (i % 5) < 4, (i % 5) == 4);
      step(v, $sformatf("burst%0d", i));
    end

    // Lock held over six UHCI accesses with AXI waiting; AXI only after release.
    for (int i = 0; i < 6; i++) begin
      v = mk(1, 1, 4'b0000, 6'(20 + i), 1, 4'b0000, 4'b0001, 12, 32'h0, 1, 0);
      step(v, $sformatf("lockA%0d", i));
    end
    step(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0001, 12, 32'h0, 0, 1), "lockA_rel");

    // Forced AXI slot is deferred by a lock and taken once the lock drops.
    for (int i = 0; i < 4; i++)
      step(mk(1, 0, 4'b0000, 6'(30 + i), 1, 4'b0000, 4'b0010, 13, 32'h0, 1, 0),
           $sformatf("lockB%0d", i));
    for (int i = 0; i < 2; i++) begin
      step(mk(1, 1, 4'b0000, 6'(40 + i), 1, 4'b0000, 4'b0010, 13, 32'h0, 1, 0),
           $sformatf("lockB_held%0d", i));
      chk("lockB_state_xforce", dbg_state, 1'b1);
    end
    step(mk(1, 0, 4'b0000, 42, 1, 4'b0000, 4'b0010, 13, 32'h0, 0, 1), "lockB_rel");
    step(mk(1, 0, 4'b0000, 43, 0, 4'b0000, 4'b0000, 0, 32'h0, 1, 0), "lockB_after");
    chk("lockB_state_upri", dbg_state, 1'b0);

    // AXI request withdrawn while forced: one cycle with no grant, then UHCI.
    for (int i = 0; i < 4; i++)
      step(mk(1, 0, 4'b0000, 6'(50 + i), 1, 4'b0000, 4'b0001, 14, 32'h0, 1, 0),
           $sformatf("drop%0d", i));
    step(mk(1, 0, 4'b0000, 54, 0, 4'b0000, 4'b0000, 0, 32'h0, 0, 0), "drop_nogrant");
    chk("drop_state_xforce", dbg_state, 1'b1);
    step(mk(1, 0, 4'b0000, 54, 0, 4'b0000, 4'b0000, 0, 32'h0, 1, 0), "drop_regrant");
    chk("drop_state_upri", dbg_state, 1'b0);

    // Reset in the cycle after a UHCI read grant cancels the pending return.
    step(mk(1, 0, 4'b0000, 5, 0, 4'b0000, 4'b0000, 0, 32'h0, 1, 0), "rst_rd");
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid", u_rvalid, 1'b0);
    chk("rst_mid_state", {dbg_state, dbg_burst_cnt, dbg_last_owner}, '0);
    step(mk(1, 0, 4'b0000, 6, 0, 4'b0000, 4'b0000, 0, 32'h0, 1, 0), "post_rst_rd");
    step(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0, 0, 0), "final_idle");
    step(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0, 0, 0), "final_idle2");

    chk("u_q_drained", 160'(u_exp_q.size()), '0);
    chk("x_q_drained", 160'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
